// File: rtl/ads131_frame_unpacker.sv
// Unpacks ADS131A0x status + channel word frames into sign-extended, channel-tagged
// samples, buffered in a first-word fall-through FIFO on a valid/ready stream.
module ads131_frame_unpacker #(
    parameter int          NUM_CH      = 4,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [7:0]  EXPECT_STAT = 8'h22
) (
    input  logic        system_clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        word_valid,
    input  logic [23:0] word_data,
    input  logic        frame_start,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [31:0] sample_data,
    output logic [1:0]  sample_channel,
    output logic [15:0] status_word,
    output logic        frame_done,
    output logic        status_error,
    output logic        frame_error,
    input  logic        clear_errors,
    output logic [7:0]  overflow_count,
    output logic [15:0] frame_count
);

    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         CW      = AW + 1;
    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CHANNELS = 2'd1,
        S_DISCARD  = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  ch_q;
    logic [15:0] status_word_q;
    logic        frame_done_q;
    logic        status_error_q;
    logic        frame_error_q;
    logic [15:0] frame_count_q;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [7:0]    overflow_q;

    logic word_is_start;
    logic word_is_data;
    logic status_bad;
    logic status_err_set;
    logic frame_err_set;
    logic push_req;
    logic pop;
    logic fifo_full;
    logic push_ok;
    logic drop;

    assign word_is_start  = word_valid & frame_start;
    assign word_is_data   = word_valid & ~frame_start;
    assign status_bad     = (word_data[23:16] != EXPECT_STAT);
    assign status_err_set = word_is_start & enable & status_bad;
    assign frame_err_set  = word_is_start & (state_q != S_IDLE);

    assign sample_valid = (count_q != '0);
    assign pop          = sample_valid & sample_ready;
    assign fifo_full    = (count_q == CW'(FIFO_DEPTH));
    assign push_req     = (state_q == S_CHANNELS) & word_is_data;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push_ok      = push_req & (~fifo_full | pop);
    assign drop         = push_req & fifo_full & ~pop;

    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            ch_q           <= 2'd0;
            status_word_q  <= 16'd0;
            frame_done_q   <= 1'b0;
            status_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
            frame_count_q  <= 16'd0;
        end else begin
            frame_done_q <= 1'b0;

            if (clear_errors)        status_error_q <= 1'b0;
            else if (status_err_set) status_error_q <= 1'b1;

            if (clear_errors)       frame_error_q <= 1'b0;
            else if (frame_err_set) frame_error_q <= 1'b1;

            // A status word restarts framing from any state; enable only gates new frames.
            if (word_is_start) begin
                ch_q <= 2'd0;
                if (enable) begin
                    status_word_q <= word_data[23:8];
                    state_q       <= status_bad ? S_DISCARD : S_CHANNELS;
                end else begin
                    state_q <= S_IDLE;
                end
            end else if (word_is_data) begin
                case (state_q)
                    S_CHANNELS: begin
                        if (ch_q == LAST_CH) begin
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                            ch_q          <= 2'd0;
                            state_q       <= S_IDLE;
                        end else begin
                            ch_q <= ch_q + 2'd1;
                        end
                    end
                    S_DISCARD: begin
                        if (ch_q == LAST_CH) begin
                            ch_q    <= 2'd0;
                            state_q <= S_IDLE;
                        end else begin
                            ch_q <= ch_q + 2'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 8'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (drop && overflow_q != 8'hFF) overflow_q <= overflow_q + 8'd1;
        end
    end

    always_ff @(posedge system_clock) begin
        if (push_ok) mem[wr_ptr_q] <= {ch_q, {8{word_data[23]}}, word_data};
    end

    // Head is forced to zero while empty so stale RAM contents never reach the port.
    assign sample_data    = sample_valid ? mem[rd_ptr_q][31:0]  : 32'd0;
    assign sample_channel = sample_valid ? mem[rd_ptr_q][33:32] : 2'd0;

    assign status_word    = status_word_q;
    assign frame_done     = frame_done_q;
    assign status_error   = status_error_q;
    assign frame_error    = frame_error_q;
    assign overflow_count = overflow_q;
    assign frame_count    = frame_count_q;

endmodule
